// File: rtl/tx_stream_sched.sv
// Two-source AXI-Stream packet scheduler: packet-granular arbitration, inter-frame gap, gate, quota, per-source counters.
// Define TX_SCHED_STRICT_PRIO_EN to make source 0 strict priority instead of round-robin.
//
// state | meaning
// IDLE  | outputs idle; arbitrates when gate & ~sched_done & any source valid
// SEND  | granted source muxed straight through to the master port
// IFG   | outputs idle for ifg_cycles cycles after a packet
module tx_stream_sched #(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNT_WIDTH        = 32,
    parameter int C_IFG_WIDTH        = 8
) (
    input  logic                            axi_aclk,
    input  logic                            axi_areset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic                            s0_axis_tvalid,
    input  logic                            s0_axis_tlast,
    output logic                            s0_axis_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic                            s1_axis_tvalid,
    input  logic                            s1_axis_tlast,
    output logic                            s1_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    input  logic                            gate,
    input  logic [C_IFG_WIDTH-1:0]          ifg_cycles,
    input  logic [C_CNT_WIDTH-1:0]          pkt_limit,
    input  logic                            clr_cntrs,
    output logic [C_CNT_WIDTH-1:0]          pkt_cnt0,
    output logic [C_CNT_WIDTH-1:0]          pkt_cnt1,
    output logic                            sched_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_IFG} state_t;

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);
    localparam logic [C_IFG_WIDTH-1:0] IFG_ONE = C_IFG_WIDTH'(1);

    state_t                   state_q;
    logic                     grant_q;
    logic                     last_grant_q;
    logic [C_IFG_WIDTH-1:0]   ifg_cnt_q;
    logic [C_CNT_WIDTH-1:0]   cnt0_q, cnt0_d;
    logic [C_CNT_WIDTH-1:0]   cnt1_q, cnt1_d;
    logic [C_CNT_WIDTH-1:0]   total_q, total_d;
    logic                     done_q, done_d;

    logic send;
    logic sel_valid;
    logic sel_last;
    logic last_beat;
    logic winner;

    assign send      = (state_q == ST_SEND);
    assign sel_valid = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_last  = grant_q ? s1_axis_tlast  : s0_axis_tlast;
    assign last_beat = send & sel_valid & sel_last & m_axis_tready;

    assign m_axis_tvalid  = send & sel_valid;
    assign m_axis_tlast   = send & sel_last;
    assign m_axis_tdata   = send ? (grant_q ? s1_axis_tdata : s0_axis_tdata) : '0;
    assign m_axis_tstrb   = send ? (grant_q ? s1_axis_tstrb : s0_axis_tstrb) : '0;
    assign m_axis_tuser   = send ? (grant_q ? s1_axis_tuser : s0_axis_tuser) : '0;
    assign s0_axis_tready = send & ~grant_q & m_axis_tready;
    assign s1_axis_tready = send &  grant_q & m_axis_tready;

    assign pkt_cnt0   = cnt0_q;
    assign pkt_cnt1   = cnt1_q;
    assign sched_done = done_q;

`ifdef TX_SCHED_STRICT_PRIO_EN
    assign winner = ~s0_axis_tvalid;
`else
    // Prefer the source that did not win last time; otherwise whoever is requesting.
    assign winner = last_grant_q ? ~s0_axis_tvalid : s1_axis_tvalid;
`endif

    // Clear beats a coincident packet completion, so that packet is never counted.
    always_comb begin
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        total_d = total_q;
        done_d  = done_q;
        if (clr_cntrs) begin
            cnt0_d  = '0;
            cnt1_d  = '0;
            total_d = '0;
            done_d  = 1'b0;
        end else if (last_beat) begin
            if (grant_q) cnt1_d = cnt1_q + CNT_ONE;
            else         cnt0_d = cnt0_q + CNT_ONE;
            total_d = total_q + CNT_ONE;
            if ((pkt_limit != '0) && (total_d == pkt_limit)) done_d = 1'b1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ifg_cnt_q    <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            total_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            total_q <= total_d;
            done_q  <= done_d;
            case (state_q)
                ST_IDLE: begin
                    if (gate && !done_q && (s0_axis_tvalid || s1_axis_tvalid)) begin
                        grant_q      <= winner;
                        last_grant_q <= winner;
                        state_q      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (last_beat) begin
                        if (ifg_cycles != '0) begin
                            ifg_cnt_q <= ifg_cycles;
                            state_q   <= ST_IFG;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                ST_IFG: begin
                    ifg_cnt_q <= ifg_cnt_q - IFG_ONE;
                    if (ifg_cnt_q == IFG_ONE) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_stream_sched.sv
// Bench for tx_stream_sched: packet-level reference model checked every cycle, directed scenarios, then random traffic.
module tb_tx_stream_sched;

    localparam int DW = 64;
    localparam int UW = 128;
    localparam int CW = 32;
    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            axi_areset;
    logic [DW-1:0]   s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic [DW/8-1:0] s0_axis_tstrb, s1_axis_tstrb, m_axis_tstrb;
    logic [UW-1:0]   s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
    logic            s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
    logic            s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
    logic            s0_axis_tready, s1_axis_tready, m_axis_tready;
    logic            gate;
    logic [IW-1:0]   ifg_cycles;
    logic [CW-1:0]   pkt_limit;
    logic            clr_cntrs;
    logic [CW-1:0]   pkt_cnt0, pkt_cnt1;
    logic            sched_done;

    tx_stream_sched #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_CNT_WIDTH       (CW),
        .C_IFG_WIDTH       (IW)
    ) dut (
        .axi_aclk      (clk),
        .axi_areset    (axi_areset),
        .s0_axis_tdata (s0_axis_tdata),
        .s0_axis_tstrb (s0_axis_tstrb),
        .s0_axis_tuser (s0_axis_tuser),
        .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast (s0_axis_tlast),
        .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata (s1_axis_tdata),
        .s1_axis_tstrb (s1_axis_tstrb),
        .s1_axis_tuser (s1_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast (s1_axis_tlast),
        .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .gate          (gate),
        .ifg_cycles    (ifg_cycles),
        .pkt_limit     (pkt_limit),
        .clr_cntrs     (clr_cntrs),
        .pkt_cnt0      (pkt_cnt0),
        .pkt_cnt1      (pkt_cnt1),
        .sched_done    (sched_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which source owns the output, idle cycles still owed, counters.
    bit            m_ok = 1'b0;
    int            m_busy, m_last, m_wait;
    logic [CW-1:0] m_cnt [2];
    logic [CW-1:0] m_total;
    bit            m_done;

    // Source generators and stimulus modes.
    int pkt [2];
    int beat[2];
    int len [2];
    bit hs  [2];
    bit src_en[2];
    bit rand_valid;
    int fix_len;
    int rdy_mode;
    bit clr_on_tlast;
    int clr_hits;

    // Output monitor.
    int cyc = 0;
    bit in_pkt;
    int last_tl;
    int beats;
    int beat_total;
    int src_log[$];
    int gap_log[$];
    int len_log[$];
    int first_log[$];

    task automatic chk(string nm, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_compare();
        logic [203:0] exp_v, act_v;
        logic [3*CW:0] exp_s, act_s;
        if (!m_ok) return;
        if (m_busy == 0)
            exp_v = {s0_axis_tvalid, s0_axis_tlast, s0_axis_tdata, s0_axis_tstrb, s0_axis_tuser, m_axis_tready, 1'b0};
        else if (m_busy == 1)
            exp_v = {s1_axis_tvalid, s1_axis_tlast, s1_axis_tdata, s1_axis_tstrb, s1_axis_tuser, 1'b0, m_axis_tready};
        else
            exp_v = '0;
        act_v = {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb, m_axis_tuser, s0_axis_tready, s1_axis_tready};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL stream cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
        end
        exp_s = {m_cnt[0], m_cnt[1], m_total, m_done};
        act_s = {pkt_cnt0, pkt_cnt1, m_total, sched_done};
        n_checks++;
        if (act_s !== exp_s) begin
            n_fail++;
            $display("FAIL status cycle %0d: cnt0/cnt1/done got %0d/%0d/%0d, expected %0d/%0d/%0d",
                     cyc, pkt_cnt0, pkt_cnt1, sched_done, m_cnt[0], m_cnt[1], m_done);
        end
    endtask

    task automatic model_update();
        bit v0, v1, endpkt;
        int w;
        v0 = s0_axis_tvalid;
        v1 = s1_axis_tvalid;
        endpkt = (m_busy == 0 && v0 && s0_axis_tlast && m_axis_tready) ||
                 (m_busy == 1 && v1 && s1_axis_tlast && m_axis_tready);
        if (axi_areset) begin
            m_ok = 1'b1;
            m_busy = -1; m_last = 1; m_wait = 0;
            m_cnt[0] = '0; m_cnt[1] = '0; m_total = '0; m_done = 1'b0;
            return;
        end
        if (!m_ok) return;
        if (m_busy >= 0) begin
            if (endpkt) begin
                m_cnt[m_busy] = m_cnt[m_busy] + 1;
                m_total = m_total + 1;
                if (pkt_limit != 0 && m_total == pkt_limit) m_done = 1'b1;
                m_wait = int'(ifg_cycles);
                m_busy = -1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (gate && !m_done && (v0 || v1)) begin
`ifdef TX_SCHED_STRICT_PRIO_EN
            w = v0 ? 0 : 1;
`else
            if (m_last == 1) w = v0 ? 0 : 1;
            else             w = v1 ? 1 : 0;
`endif
            m_busy = w;
            m_last = w;
        end
        if (clr_cntrs) begin
            m_cnt[0] = '0; m_cnt[1] = '0; m_total = '0; m_done = 1'b0;
        end
    endtask

    task automatic monitor();
        if (m_axis_tvalid && m_axis_tready) begin
            beat_total++;
            if (!in_pkt) begin
                in_pkt = 1'b1;
                beats = 0;
                if (last_tl >= 0) gap_log.push_back(cyc - last_tl - 1);
                first_log.push_back(int'(m_axis_tdata[63:56]));
            end
            beats++;
            if (m_axis_tlast) begin
                in_pkt = 1'b0;
                src_log.push_back(int'(m_axis_tdata[63:56]));
                len_log.push_back(beats);
                last_tl = cyc;
            end
        end
        if (axi_areset) begin
            in_pkt = 1'b0;
            last_tl = -1;
        end
    endtask

    task automatic drive();
        for (int s = 0; s < 2; s++) begin
            if (hs[s]) begin
                if (beat[s] == len[s] - 1) begin
                    pkt[s]++;
                    beat[s] = 0;
                    len[s] = (fix_len != 0) ? fix_len : int'($urandom_range(1, 5));
                end else begin
                    beat[s]++;
                end
            end
        end
        s0_axis_tvalid = src_en[0] && (!rand_valid || $urandom_range(0, 3) != 0);
        s0_axis_tdata  = {8'd0, pkt[0][23:0], beat[0]};
        s0_axis_tlast  = (beat[0] == len[0] - 1);
        s0_axis_tstrb  = 8'($urandom);
        s0_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
        s1_axis_tvalid = src_en[1] && (!rand_valid || $urandom_range(0, 3) != 0);
        s1_axis_tdata  = {8'd1, pkt[1][23:0], beat[1]};
        s1_axis_tlast  = (beat[1] == len[1] - 1);
        s1_axis_tstrb  = 8'($urandom);
        s1_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
        if (clr_on_tlast) begin
            clr_cntrs = s0_axis_tready && s0_axis_tvalid && s0_axis_tlast && m_axis_tready;
            if (clr_cntrs) clr_hits++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        model_compare();
        monitor();
        hs[0] = s0_axis_tvalid && s0_axis_tready;
        hs[1] = s1_axis_tvalid && s1_axis_tready;
        model_update();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_logs();
        src_log.delete(); gap_log.delete(); len_log.delete(); first_log.delete();
        in_pkt = 1'b0; last_tl = -1; beat_total = 0;
    endtask

    task automatic start_test();
        axi_areset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            pkt[s] = 0; beat[s] = 0; hs[s] = 1'b0;
            len[s] = (fix_len != 0) ? fix_len : int'($urandom_range(1, 5));
        end
        drive();
        tick();
        tick();
        axi_areset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_pkts(int n, int budget, string nm);
        int k = 0;
        while (src_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({"timeout_", nm}, (src_log.size() >= n) ? 1 : 0, 1);
    endtask

    initial begin
        int bt, fl, k;
        int exp_order[4];
        axi_areset = 1'b1; gate = 1'b1; ifg_cycles = '0; pkt_limit = '0; clr_cntrs = 1'b0;
        m_axis_tready = 1'b1; clr_on_tlast = 1'b0; clr_hits = 0;
        rand_valid = 1'b0; rdy_mode = 0;

        // Round-robin order and arbitration bubble, 4-beat packets.
        src_en = '{1'b1, 1'b1}; fix_len = 4;
        start_test();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_treadys", {s0_axis_tready, s1_axis_tready}, 0);
        chk("rst_cnts", pkt_cnt0 + pkt_cnt1, 0);
        chk("rst_done", sched_done, 0);
        wait_pkts(4, 200, "rr");
`ifdef TX_SCHED_STRICT_PRIO_EN
        exp_order = '{0, 0, 0, 0};
        chk("rr_cnt0", pkt_cnt0, 4);
        chk("rr_cnt1", pkt_cnt1, 0);
`else
        exp_order = '{0, 1, 0, 1};
        chk("rr_cnt0", pkt_cnt0, 2);
        chk("rr_cnt1", pkt_cnt1, 2);
`endif
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("order_%0d", i), src_log[i], exp_order[i]);
            chk($sformatf("len_%0d", i), len_log[i], 4);
        end
        for (int i = 0; i < 3; i++) chk($sformatf("gap0_%0d", i), gap_log[i], 1);

        // IFG of 3: four idle cycles between packets.
        src_en = '{1'b1, 1'b0}; fix_len = 2; ifg_cycles = 8'd3;
        start_test();
        wait_pkts(3, 200, "ifg");
        chk("gap3_0", gap_log[0], 4);
        chk("gap3_1", gap_log[1], 4);
        chk("ifg_len", len_log[0], 2);
        ifg_cycles = '0;

        // Quota of 5, hold off, clear and resume.
        src_en = '{1'b1, 1'b1}; fix_len = 2; pkt_limit = 32'd5;
        start_test();
        k = 0;
        while (!sched_done && k < 300) begin tick(); k++; end
        chk("quota_done", sched_done, 1);
        chk("quota_pkts", src_log.size(), 5);
`ifdef TX_SCHED_STRICT_PRIO_EN
        chk("quota_cnt0", pkt_cnt0, 5);
        chk("quota_cnt1", pkt_cnt1, 0);
`else
        chk("quota_cnt0", pkt_cnt0, 3);
        chk("quota_cnt1", pkt_cnt1, 2);
`endif
        bt = beat_total;
        repeat (20) tick();
        chk("quota_hold_beats", beat_total, bt);
        chk("quota_hold_done", sched_done, 1);
        clr_cntrs = 1'b1;
        tick();
        clr_cntrs = 1'b0;
        chk("clr_cnt0", pkt_cnt0, 0);
        chk("clr_cnt1", pkt_cnt1, 0);
        chk("clr_done", sched_done, 0);
        wait_pkts(6, 100, "resume");
`ifdef TX_SCHED_STRICT_PRIO_EN
        chk("resume_cnt", pkt_cnt0, 1);
`else
        chk("resume_cnt", pkt_cnt1, 1);
`endif
        pkt_limit = '0;

        // Gate dropped mid-packet under tready toggling.
        src_en = '{1'b1, 1'b0}; fix_len = 6; rdy_mode = 1;
        start_test();
        k = 0;
        while (beat_total < 1 && k < 50) begin tick(); k++; end
        gate = 1'b0;
        wait_pkts(1, 100, "gate_pkt");
        chk("gate_len", len_log[0], 6);
        bt = beat_total;
        repeat (20) tick();
        chk("gate_hold", beat_total, bt);
        gate = 1'b1;
        wait_pkts(2, 100, "gate_resume");
        rdy_mode = 0;

        // Clear coincident with a tlast beat.
        src_en = '{1'b1, 1'b0}; fix_len = 3;
        start_test();
        wait_pkts(1, 100, "clr1");
        chk("clr_pre", pkt_cnt0, 1);
        clr_on_tlast = 1'b1;
        wait_pkts(2, 100, "clr2");
        clr_on_tlast = 1'b0;
        clr_cntrs = 1'b0;
        chk("clr_tlast_hit", clr_hits, 1);
        chk("clr_tlast_cnt", pkt_cnt0, 0);

        // Reset in the middle of a source-0 packet.
        src_en = '{1'b1, 1'b1}; fix_len = 6;
        start_test();
        wait_pkts(2, 200, "rst_pre");
        repeat (3) tick();
        axi_areset = 1'b1;
        tick();
        axi_areset = 1'b0;
        chk("mrst_tvalid", m_axis_tvalid, 0);
        chk("mrst_treadys", {s0_axis_tready, s1_axis_tready}, 0);
        chk("mrst_cnts", pkt_cnt0 + pkt_cnt1, 0);
        fl = first_log.size();
        k = 0;
        while (first_log.size() <= fl && k < 50) begin tick(); k++; end
        chk("mrst_first_src", first_log[fl], 0);

        // Random traffic against the model.
        src_en = '{1'b1, 1'b1}; fix_len = 0; rand_valid = 1'b1; rdy_mode = 2;
        start_test();
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                ifg_cycles = IW'($urandom_range(0, 3));
                gate = ($urandom_range(0, 5) != 0);
                pkt_limit = ($urandom_range(0, 2) == 0) ? m_total + CW'($urandom_range(1, 4)) : '0;
            end
            clr_cntrs = ($urandom_range(0, 59) == 0);
            axi_areset = ($urandom_range(0, 399) == 0);
            tick();
        end
        axi_areset = 1'b0;
        chk("rand_progress", (src_log.size() > 20) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_stream_sched.md
Name: tx_stream_sched

Overview:
- Two-source packet scheduler in front of the 10G TX datapath.
- Arbitrates packets from two AXI-Stream generator sources onto one AXI-Stream master. Arbitration is round-robin and only switches at packet boundaries.
- Inserts a programmable inter-frame gap (IFG), applies a global gate and a packet quota, and keeps per-source packet counters for the AXI-Lite register block.

Parameters:
- C_AXIS_DATA_WIDTH, 64, tdata width for both slave ports and the master port.
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- C_CNT_WIDTH, 32, width of the packet counters and the quota.
- C_IFG_WIDTH, 8, width of the IFG setting, in cycles.

Ports:
- axi_aclk  in  1  sole clock.
- axi_areset  in  1  synchronous, active-high reset.
- s0_axis_tdata/tstrb/tuser/tvalid/tlast  in  64/8/128/1/1  source 0 stream.
- s0_axis_tready  out  1  source 0 ready.
- s1_axis_tdata/tstrb/tuser/tvalid/tlast  in  64/8/128/1/1  source 1 stream.
- s1_axis_tready  out  1  source 1 ready.
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  64/8/128/1/1  merged output stream.
- m_axis_tready  in  1  downstream ready.
- gate  in  1  1 = scheduling allowed.
- ifg_cycles  in  C_IFG_WIDTH  idle cycles after each packet.
- pkt_limit  in  C_CNT_WIDTH  total packet quota; 0 = unlimited.
- clr_cntrs  in  1  level; clears counters and the quota-done condition.
- pkt_cnt0  out  C_CNT_WIDTH  packets completed from source 0.
- pkt_cnt1  out  C_CNT_WIDTH  packets completed from source 1.
- sched_done  out  1  quota reached.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high (axi_areset), asserted on any cycle.
- Reset values:
  - state = IDLE, last_grant = 1 (so source 0 wins first), ifg_cnt = 0.
  - pkt_cnt0 = pkt_cnt1 = 0, sched_done = 0.
  - Outputs: all m_axis_* = 0, both s*_tready = 0.
- Beat: a source beat completes on tvalid & tready. A packet ends on a beat with tlast.

States:
- IDLE
  - m_axis_tvalid = 0, both treadys = 0.
  - If gate & ~sched_done & (s0_tvalid | s1_tvalid):
    - Requester != last_grant wins if valid; otherwise the sole requester wins.
    - grant <= winner, last_grant <= winner, next state SEND.
  - Arbitration costs 1 cycle; the first beat is presented the cycle after the decision.
- SEND
  - Zero-latency combinational mux: m_axis_* = s[grant]_axis_*, s[grant]_tready = m_axis_tready, other tready = 0.
  - On the completing tlast beat:
    - pkt_cnt[grant] += 1, total += 1.
    - If pkt_limit != 0 and the new total == pkt_limit, set sched_done.
    - Next state is IFG if ifg_cycles != 0, else IDLE.
  - gate is ignored in SEND: a packet in progress always completes.
- IFG
  - Outputs idle, as in IDLE.
  - ifg_cnt is loaded with ifg_cycles on entry and decrements each cycle; exit to IDLE when ifg_cnt == 1.
  - Exactly ifg_cycles idle cycles follow the last beat, before the 1-cycle arbitration cycle.
  - ifg_cycles is sampled at the tlast beat only.

Arithmetic and status:
- Internal total counter is C_CNT_WIDTH wide. All counters wrap modulo 2^C_CNT_WIDTH with no saturation.
- sched_done stays high until clr_cntrs or reset; no new grants are issued while it is high.
- clr_cntrs:
  - Zeroes pkt_cnt0, pkt_cnt1, total and sched_done on the next edge.
  - Clear wins over a simultaneous increment; that packet is not counted.
  - Does not abort a packet in flight.
- pkt_limit changed below the current total: sched_done is not set until the total wraps to equal it. Software must clear the counters first.

Error tolerance:
- Source tvalid deasserting mid-packet: m_axis_tvalid follows it; the block waits in SEND and does not re-arbitrate.
- A tvalid/tlast on the non-granted source is ignored (held off by tready = 0).

Optional Feature:
- Macro: TX_SCHED_STRICT_PRIO_EN.
- Defined: IDLE arbitration is strict priority; source 0 always wins when valid, and last_grant is ignored.
- Undefined: round-robin as above.
- Counters, IFG and quota are identical in both builds.

Test Plan:
- Both sources continuously valid, 4-beat packets, ifg_cycles = 0, m_axis_tready = 1:
  - Output packet order is 0,1,0,1.
  - Each packet is 4 contiguous beats followed by 1 idle arbitration cycle.
  - pkt_cnt0 = pkt_cnt1 = 2 after 4 packets.
- ifg_cycles = 3, source 0 only, 2-beat packets: m_axis_tvalid low for exactly 4 cycles (3 IFG + 1 arbitration) between each tlast beat and the next first beat.
- pkt_limit = 5, both sources valid:
  - sched_done rises on the 5th tlast beat, with pkt_cnt0 = 3 and pkt_cnt1 = 2.
  - No further grants follow.
  - Pulsing clr_cntrs zeroes all counters and scheduling resumes.
- gate dropped on the 2nd beat of a 6-beat packet with m_axis_tready toggling 1,0,1: packet completes all 6 beats intact, then the block stays in IDLE until gate = 1.
- clr_cntrs asserted on the same cycle as a tlast beat: pkt_cnt becomes 0, not 1.
- axi_areset asserted mid-packet: next cycle m_axis_tvalid = 0, both treadys = 0, counters = 0, and after release source 0 wins first.
- Build with TX_SCHED_STRICT_PRIO_EN, both sources valid: three consecutive packets all from source 0.
